// File: rtl/btn_debouncer_mc.sv
// Multi-channel button debouncer: 2-FF sync, shared tick prescaler, per-channel press/release pulses.
// Optional hold auto-repeat is compiled in when BTN_AUTOREPEAT_EN is defined.
module btn_debouncer_mc #(
    parameter int CH           = 4,
    parameter int DIV          = 8,
    parameter int N            = 3,
    parameter int REPEAT_DELAY = 4,
    parameter int REPEAT_RATE  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] btn_raw,
    output logic [CH-1:0] btn_level,
    output logic [CH-1:0] press_pulse,
    output logic [CH-1:0] release_pulse,
    output logic [CH-1:0] repeat_pulse
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = $clog2(N + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    if (CH < 1 || DIV < 1 || N < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("btn_debouncer_mc: all parameters must be >= 1");
    end

    logic [CH-1:0] r_sync1;
    logic [CH-1:0] r_sync2;
    logic [CH-1:0] r_level;
    logic [CH-1:0] r_press;
    logic [CH-1:0] r_release;
    logic [DW-1:0] r_div;
    logic [CW-1:0] r_cnt [CH];
    logic          w_tick;
    logic [CH-1:0] w_accept;

    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_div   <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            r_div   <= w_tick ? '0 : r_div + 1'b1;
        end
    end

    // A channel accepts its new level on the tick that completes N differing samples.
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < CH; i++) begin
            w_accept[i] = w_tick && (r_sync2[i] != r_level[i]) && (r_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            for (int i = 0; i < CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_press   <= '0;
            r_release <= '0;
            for (int i = 0; i < CH; i++) begin
                if (w_tick) begin
                    if (w_accept[i]) begin
                        r_level[i]   <= r_sync2[i];
                        r_cnt[i]     <= '0;
                        r_press[i]   <= r_sync2[i];
                        r_release[i] <= ~r_sync2[i];
                    end else if (r_sync2[i] != r_level[i]) begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end else begin
                        r_cnt[i] <= '0;
                    end
                end
            end
        end
    end

    assign btn_level     = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;

`ifdef BTN_AUTOREPEAT_EN
    localparam int HW = $clog2(REPEAT_DELAY + 1);
    localparam int RW = $clog2(REPEAT_RATE + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

    logic [HW-1:0] r_hold [CH];
    logic [RW-1:0] r_rate [CH];
    logic [CH-1:0] r_repeat;

    // Hold counter saturates at REPEAT_DELAY; the rate counter then paces later repeats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_repeat <= '0;
            for (int i = 0; i < CH; i++) begin
                r_hold[i] <= '0;
                r_rate[i] <= '0;
            end
        end else begin
            r_repeat <= '0;
            for (int i = 0; i < CH; i++) begin
                if (w_accept[i]) begin
                    r_hold[i] <= '0;
                    r_rate[i] <= '0;
                end else if (w_tick && r_level[i]) begin
                    if (r_hold[i] != HOLD_MAX) begin
                        r_hold[i] <= r_hold[i] + 1'b1;
                        if (r_hold[i] == HOLD_LAST) begin
                            r_repeat[i] <= 1'b1;
                        end
                    end else if (r_rate[i] == RATE_LAST) begin
                        r_rate[i]   <= '0;
                        r_repeat[i] <= 1'b1;
                    end else begin
                        r_rate[i] <= r_rate[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign repeat_pulse = r_repeat;
`else
    assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_btn_debouncer_mc.sv
// Bench for btn_debouncer_mc: scoreboard of expected press/release events, stimulus table,
// and hand-written sequences for chatter, auto-repeat (BTN_AUTOREPEAT_EN) and mid-debounce reset.
module tb_btn_debouncer_mc;

    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] btn_raw = '0;
    logic [CH-1:0] btn_level;
    logic [CH-1:0] press_pulse;
    logic [CH-1:0] release_pulse;
    logic [CH-1:0] repeat_pulse;

    always #5 clk = ~clk;

    btn_debouncer_mc #(
        .CH(CH), .DIV(8), .N(3), .REPEAT_DELAY(4), .REPEAT_RATE(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Event word is {press mask, release mask}.
    logic [2*CH-1:0] exp_q[$];
    logic [2*CH-1:0] mon_ev;
    logic [2*CH-1:0] mon_exp;

    typedef struct {
        logic [CH-1:0] raw;
        int            cycles;
        logic [CH-1:0] press;
        logic [CH-1:0] rel;
        logic [CH-1:0] level;
    } step_t;

    step_t steps[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input logic [CH-1:0] press, input logic [CH-1:0] rel);
        exp_q.push_back({press, rel});
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon_ev = {press_pulse, release_pulse};
            if (mon_ev != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 32'(mon_ev), 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("event", 32'(mon_ev), 32'(mon_exp));
                end
                check("press_release_overlap", 32'(press_pulse & release_pulse), 32'd0);
            end
            if (release_pulse != '0) begin
                check("repeat_in_release_cycle", 32'(repeat_pulse & release_pulse), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        int off;
        int rep_n;
        int rep_first;
        int rep_prev;
        int gap_bad;

        steps[0] = '{4'b1101, 30, 4'b1100, 4'b0000, 4'b1101};
        steps[1] = '{4'b0001, 30, 4'b0000, 4'b1100, 4'b0001};
        steps[2] = '{4'b0011, 30, 4'b0010, 4'b0000, 4'b0011};
        steps[3] = '{4'b0001, 30, 4'b0000, 4'b0010, 4'b0001};
        steps[4] = '{4'b1111, 30, 4'b1110, 4'b0000, 4'b1111};
        steps[5] = '{4'b0000, 30, 4'b0000, 4'b1111, 4'b0000};
        steps[6] = '{4'b0101, 30, 4'b0101, 4'b0000, 4'b0101};
        steps[7] = '{4'b1010, 30, 4'b1010, 4'b0101, 4'b1010};
        steps[8] = '{4'b0000, 30, 4'b0000, 4'b1010, 4'b0000};

        // Reset state
        cycles(3);
        check("reset_level", 32'(btn_level), 32'd0);
        check("reset_press", 32'(press_pulse), 32'd0);
        check("reset_release", 32'(release_pulse), 32'd0);
        check("reset_repeat", 32'(repeat_pulse), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        cycles(2);

        // ch0 chatters every clk, then settles high: one press only
        push_ev(4'b0001, 4'b0000);
        for (int i = 0; i < 30; i++) begin
            btn_raw[0] = ~btn_raw[0];
            cycles(1);
        end
        btn_raw[0] = 1'b1;
        cycles(32);
        check("t1_level", 32'(btn_level), 32'h1);
        check("t1_queue", 32'(exp_q.size()), 32'd0);

        // ch1 short 12-clk blip is rejected
        btn_raw[1] = 1'b1;
        cycles(12);
        btn_raw[1] = 1'b0;
        cycles(40);
        check("t2_level", 32'(btn_level), 32'h1);
        check("t2_queue", 32'(exp_q.size()), 32'd0);

        for (int i = 0; i < 9; i++) begin
            if ((steps[i].press | steps[i].rel) != '0) begin
                push_ev(steps[i].press, steps[i].rel);
            end
            btn_raw = steps[i].raw;
            cycles(steps[i].cycles);
            check($sformatf("step%0d_level", i), 32'(btn_level), 32'(steps[i].level));
            check($sformatf("step%0d_queue", i), 32'(exp_q.size()), 32'd0);
        end

        // ch0 held, random chatter, then steady low: one release only
        push_ev(4'b0001, 4'b0000);
        btn_raw = 4'b0001;
        cycles(30);
        push_ev(4'b0000, 4'b0001);
        for (int i = 0; i < 20; i++) begin
            btn_raw[0] = 1'($urandom_range(0, 1));
            cycles(1);
        end
        btn_raw[0] = 1'b0;
        cycles(36);
        check("t4_level", 32'(btn_level), 32'h0);
        check("t4_queue", 32'(exp_q.size()), 32'd0);

        // ch1 held 200 clk after its press: auto-repeat cadence
        push_ev(4'b0010, 4'b0000);
        btn_raw[1] = 1'b1;
        found = 0;
        for (int j = 0; j < 40 && found == 0; j++) begin
            @(negedge clk);
            if (press_pulse[1]) found = 1;
        end
        check("t5_press_seen", 32'(found), 32'd1);
        rep_n = 0;
        rep_first = 0;
        rep_prev = 0;
        gap_bad = 0;
        for (int j = 1; j <= 200; j++) begin
            @(negedge clk);
            if (repeat_pulse[1]) begin
                if (rep_n == 0) rep_first = j;
                else if (j - rep_prev != 16) gap_bad++;
                rep_prev = j;
                rep_n++;
            end
        end
`ifdef BTN_AUTOREPEAT_EN
        check("t5_repeat_count", 32'(rep_n), 32'd11);
        check("t5_repeat_first", 32'(rep_first), 32'd32);
        check("t5_repeat_gaps", 32'(gap_bad), 32'd0);
`else
        check("t5_repeat_count", 32'(rep_n), 32'd0);
`endif
        push_ev(4'b0000, 4'b0010);
        btn_raw[1] = 1'b0;
        cycles(40);
        check("t5_level", 32'(btn_level), 32'h0);
        check("t5_queue", 32'(exp_q.size()), 32'd0);

        // Reset while ch0 has two differing ticks counted
        push_ev(4'b0100, 4'b0000);
        btn_raw[2] = 1'b1;
        cycles(30);
        check("t6_pre_level", 32'(btn_level), 32'h4);
        btn_raw[0] = 1'b1;
        repeat (18) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_level", 32'(btn_level), 32'd0);
        check("t6_rst_press", 32'(press_pulse), 32'd0);
        check("t6_rst_release", 32'(release_pulse), 32'd0);
        check("t6_rst_repeat", 32'(repeat_pulse), 32'd0);
        push_ev(4'b0101, 4'b0000);
        cycles(3);
        @(negedge clk);
        #1 rst_n = 1'b1;
        off = 0;
        for (int j = 1; j <= 60 && off == 0; j++) begin
            @(negedge clk);
            if (press_pulse[0]) off = j;
        end
        check("t6_press_latency", 32'(off), 32'd24);
        push_ev(4'b0000, 4'b0101);
        btn_raw = '0;
        cycles(40);
        check("t6_level", 32'(btn_level), 32'h0);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
